// File: rtl/dmem_pkg.sv
// dmem_pkg: shared sizes, state encoding, port indices and the address check for the data-memory arbiter
package dmem_pkg;
   localparam int DEPTH = 1024;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int DATA_W = 64;
   localparam logic [63:0] MEM_BYTES = 64'(DEPTH * 8);
   localparam int PORT_CPU = 0;
   localparam int PORT_DBG = 1;
   typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
   function automatic logic addr_ok(input logic [63:0] a);
      return (a < MEM_BYTES) && (a[2:0] == 3'd0);
   endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: two-port request/response bus between requesters and the data-memory arbiter
interface dmem_arbiter_if;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [1:0] req_write;
   logic [2*dmem_pkg::DATA_W-1:0] req_addr;
   logic [2*dmem_pkg::DATA_W-1:0] req_wdata;
   logic [1:0] resp_valid;
   logic [1:0] resp_err;
   logic [dmem_pkg::DATA_W-1:0] resp_rdata;
   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_err, resp_rdata
   );
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_err, resp_rdata
   );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-request round-robin arbiter; the pointer names the port that wins a tie
module rr_arb2 import dmem_pkg::*; (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       adv,
   output logic [1:0] gnt
);
   logic ptr;
   // a lone request always wins; a tie goes to the pointer's port
   always_comb gnt = (req == 2'b11) ? (ptr ? 2'b10 : 2'b01) : req;
   // after a grant the pointer moves to the port that did not win
   always_ff @(posedge clk)
      ptr <= !reset ? 1'b0 : (adv ? gnt[PORT_CPU] : ptr);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the CPU and debug ports with range checking
module dmem_arbiter import dmem_pkg::*; (
   input  logic              clk,
   input  logic              reset,
   dmem_arbiter_if.slave     bus,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   state_t state;
   logic [1:0] gnt;
   logic [1:0] resp_q;
   logic [1:0] err_q;
   logic load_q;
   logic busy_q;
   logic win;
   logic grant;
   logic ok;
   logic [DATA_W-1:0] addr;
   logic [DATA_W-1:0] wdata;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (bus.req_valid),
      .adv   (grant),
      .gnt   (gnt)
   );

   // winner selection, range check and memory drive; everything is held low while reset is asserted
   always_comb begin
      win = gnt[PORT_DBG];
      addr = win ? bus.req_addr[2*DATA_W-1:DATA_W] : bus.req_addr[DATA_W-1:0];
      wdata = win ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
      ok = addr_ok(addr);
      grant = reset && (state == IDLE) && (bus.req_valid != 2'b00);
      bus.req_ready = grant ? gnt : 2'b00;
      mem_en = grant && ok;
      mem_we = mem_en && bus.req_write[win];
      mem_addr = mem_en ? addr[ADDR_W+2:3] : '0;
      mem_wdata = mem_we ? wdata : '0;
      bus.resp_valid = reset ? resp_q : 2'b00;
      bus.resp_err = reset ? err_q : 2'b00;
      bus.resp_rdata = (reset && load_q) ? mem_rdata : '0;
      busy = reset && busy_q;
   end

   // two-state FSM: a grant in IDLE registers the response that RESP presents for one cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         resp_q <= 2'b00;
         err_q <= 2'b00;
         load_q <= 1'b0;
         busy_q <= 1'b0;
      end else if (state == IDLE && bus.req_valid != 2'b00) begin
         state <= RESP;
         resp_q <= gnt;
         err_q <= ok ? 2'b00 : gnt;
         load_q <= ok && !bus.req_write[win];
         busy_q <= 1'b1;
      end else begin
         state <= IDLE;
         resp_q <= 2'b00;
         err_q <= 2'b00;
         load_q <= 1'b0;
         busy_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural memory and reference arbiter
module tb_dmem_arbiter;
   import dmem_pkg::*;

   typedef struct packed {
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
   } req_t;

   typedef struct packed {
      logic [1:0]  vld;
      logic [1:0]  err;
      logic [63:0] rdata;
   } rsp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic mem_en;
   logic mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic busy;

   always #5 clk = ~clk;

   dmem_arbiter_if bus();

   dmem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   req_t pq0[$];
   req_t pq1[$];
   rsp_t sb[$];
   logic [63:0] mem [DEPTH];
   logic [63:0] shadow [DEPTH];
   int n_err = 0;
   int n_chk = 0;
   int cyc = 0;
   int gap_chk = 0;
   int last_g [2];
   logic m_state = 1'b0;
   logic m_ptr = 1'b0;
   logic [1:0] acc = 2'b00;

   logic m_w;
   logic m_ok;
   logic m_we;
   logic [63:0] m_a;
   logic [63:0] m_wd;
   rsp_t m_e;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic req_t mk(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
      req_t r;
      r.we = we;
      r.addr = addr;
      r.wdata = wdata;
      return r;
   endfunction

   task automatic wait_idle(input int budget);
      int k = 0;
      while ((pq0.size() != 0 || pq1.size() != 0 || sb.size() != 0 || m_state) && k < budget) begin
         @(posedge clk);
         k++;
      end
      repeat (2) @(posedge clk);
      check("drain", 64'(pq0.size() + pq1.size() + sb.size()), 64'd0);
   endtask

   // registered-read single-port memory
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = 64'h5A00_0000 + 64'(i);
         shadow[i] = 64'h5A00_0000 + 64'(i);
      end
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] = mem_wdata;
         end
      end
   end

   // requester driver: each port presents its queue head until accepted
   initial begin
      bus.req_valid = 2'b00;
      bus.req_write = 2'b00;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (acc[0] && pq0.size() != 0) void'(pq0.pop_front());
         if (acc[1] && pq1.size() != 0) void'(pq1.pop_front());
         bus.req_valid[0] = pq0.size() != 0;
         bus.req_valid[1] = pq1.size() != 0;
         if (pq0.size() != 0) begin
            bus.req_write[0] = pq0[0].we;
            bus.req_addr[63:0] = pq0[0].addr;
            bus.req_wdata[63:0] = pq0[0].wdata;
         end
         if (pq1.size() != 0) begin
            bus.req_write[1] = pq1[0].we;
            bus.req_addr[127:64] = pq1[0].addr;
            bus.req_wdata[127:64] = pq1[0].wdata;
         end
      end
   end

   // reference arbiter: checks grants and memory drive, pushes expected responses, pops on response
   initial begin
      last_g[0] = -1;
      last_g[1] = -1;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            check("rst_ready", 64'(bus.req_ready), 64'd0);
            check("rst_resp", 64'({bus.resp_valid, bus.resp_err}), 64'd0);
            check("rst_mem_en", 64'({mem_en, mem_we}), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            m_state = 1'b0;
            m_ptr = 1'b0;
            acc = 2'b00;
            sb.delete();
         end else if (!m_state) begin
            acc = 2'b00;
            check("idle_resp", 64'({bus.resp_valid, busy}), 64'd0);
            if (bus.req_valid == 2'b00) begin
               check("idle_ready", 64'(bus.req_ready), 64'd0);
               check("idle_mem_en", 64'(mem_en), 64'd0);
            end else begin
               m_w = (bus.req_valid == 2'b11) ? m_ptr : bus.req_valid[1];
               m_a = m_w ? bus.req_addr[127:64] : bus.req_addr[63:0];
               m_wd = m_w ? bus.req_wdata[127:64] : bus.req_wdata[63:0];
               m_we = bus.req_write[m_w];
               m_ok = (m_a < 64'd8192) && (m_a[2:0] == 3'd0);
               check("grant", 64'(bus.req_ready), m_w ? 64'd2 : 64'd1);
               check("mem_en", 64'(mem_en), 64'(m_ok));
               if (m_ok) begin
                  check("mem_we", 64'(mem_we), 64'(m_we));
                  check("mem_addr", 64'(mem_addr), 64'(m_a[12:3]));
                  if (m_we) check("mem_wdata", mem_wdata, m_wd);
               end
               m_e.vld = m_w ? 2'b10 : 2'b01;
               m_e.err = m_ok ? 2'b00 : m_e.vld;
               m_e.rdata = (m_ok && !m_we) ? shadow[m_a[12:3]] : 64'd0;
               if (m_ok && m_we) shadow[m_a[12:3]] = m_wd;
               sb.push_back(m_e);
               if (gap_chk != 0 && last_g[m_w] >= 0) check("gap", 64'(cyc - last_g[m_w]), 64'(gap_chk));
               last_g[m_w] = cyc;
               m_ptr = !m_w;
               m_state = 1'b1;
               acc = m_e.vld;
            end
         end else begin
            acc = 2'b00;
            check("resp_ready", 64'(bus.req_ready), 64'd0);
            check("busy", 64'(busy), 64'd1);
            m_e = (sb.size() != 0) ? sb.pop_front() : '0;
            check("resp_valid", 64'(bus.resp_valid), 64'(m_e.vld));
            check("resp_err", 64'(bus.resp_err), 64'(m_e.err));
            check("resp_rdata", bus.resp_rdata, m_e.rdata);
            m_state = 1'b0;
         end
      end
   end

   // time limit so the bench always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // test sequence
   initial begin
      logic found;
      for (int i = 0; i < 4; i++) begin
         pq0.push_back(mk(1'b0, 64'(i * 8), 64'd0));
         pq1.push_back(mk(1'b0, 64'h100 + 64'(i * 8), 64'd0));
      end
      repeat (4) @(posedge clk);
      gap_chk = 4;
      last_g[0] = -1;
      last_g[1] = -1;
      #1 reset = 1'b1;
      wait_idle(100);
      gap_chk = 0;
      pq0.push_back(mk(1'b1, 64'h10, 64'hDEAD_BEEF));
      wait_idle(20);
      pq0.push_back(mk(1'b0, 64'h10, 64'd0));
      wait_idle(20);
      pq1.push_back(mk(1'b0, 64'h2000, 64'd0));
      pq1.push_back(mk(1'b0, 64'h1_0000_0000, 64'd0));
      pq1.push_back(mk(1'b0, 64'h0C, 64'd0));
      wait_idle(40);
      gap_chk = 2;
      last_g[0] = -1;
      last_g[1] = -1;
      pq0.push_back(mk(1'b0, 64'h10, 64'd0));
      pq0.push_back(mk(1'b0, 64'h18, 64'd0));
      pq0.push_back(mk(1'b0, 64'h20, 64'd0));
      wait_idle(40);
      gap_chk = 0;
      pq1.push_back(mk(1'b0, 64'h18, 64'd0));
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(posedge clk);
         found = acc[1];
      end
      check("mid_grant", 64'(found), 64'd1);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      pq0.push_back(mk(1'b0, 64'h28, 64'd0));
      pq1.push_back(mk(1'b0, 64'h30, 64'd0));
      wait_idle(40);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
